// File: rtl/router_out_port_if.sv
// Output-port bundle: FIFO read side, delivered byte stream and status counters.
interface router_out_port_if;
    // m_valid/m_ready: a beat transfers on a rising edge where both are high;
    // once m_valid is raised, m_data/m_last/m_err hold until that transfer.
    logic       vld_in;
    logic [7:0] data_in;
    logic       soft_reset;
    logic       read_enb;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_err;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    modport master (
        input  vld_in, data_in, soft_reset, m_ready,
        output read_enb, m_data, m_valid, m_last, m_err, pkt_cnt, err_cnt, dbg_state
    );

    modport slave (
        output vld_in, data_in, soft_reset, m_ready,
        input  read_enb, m_data, m_valid, m_last, m_err, pkt_cnt, err_cnt, dbg_state
    );
endinterface

// File: rtl/router_out_port.sv
// Router output port: reads bytes from the output FIFO, frames them into packets
// (header / payload / parity) and delivers them through a 2-entry registered buffer.
module router_out_port #(
    parameter int PORT_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    router_out_port_if.master port_if
);
    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2
    } state_e;

    state_e     state_q;
    logic [5:0] cnt_q;
    logic [7:0] par_q;
    logic       addr_err_q;
    logic       in_flight_q;
    logic       hd_vld_q, hd_last_q, hd_err_q;
    logic [7:0] hd_data_q;
    logic       tl_vld_q, tl_last_q, tl_err_q;
    logic [7:0] tl_data_q;
    logic [7:0] pkt_cnt_q, err_cnt_q;

    logic       pop, push, rd_en, in_last, in_err, abort;
    logic [2:0] occ;
    logic [1:0] err_inc;
    logic [8:0] err_sum, pkt_sum;

    always_comb begin
        pop     = hd_vld_q & port_if.m_ready;
        push    = in_flight_q & ~port_if.soft_reset;
        occ     = {2'b00, hd_vld_q} + {2'b00, tl_vld_q};
        rd_en   = ~reset & port_if.vld_in & ~port_if.soft_reset &
                  ((occ + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));
        in_last = (state_q == ST_PARITY);
        in_err  = in_last & ((port_if.data_in != par_q) | addr_err_q);
        // A flush is an abort only if it discards something: a partial packet or beats not popped this cycle.
        abort   = port_if.soft_reset & ((state_q != ST_HDR) | (occ > {2'b00, pop}));
        err_inc = {1'b0, pop & hd_last_q & hd_err_q} + {1'b0, abort};
        err_sum = {1'b0, err_cnt_q} + {7'b0, err_inc};
        pkt_sum = {1'b0, pkt_cnt_q} + {8'b0, pop & hd_last_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HDR;
            cnt_q       <= 6'd0;
            par_q       <= 8'h00;
            addr_err_q  <= 1'b0;
            in_flight_q <= 1'b0;
            hd_vld_q    <= 1'b0;
            hd_last_q   <= 1'b0;
            hd_err_q    <= 1'b0;
            hd_data_q   <= 8'h00;
            tl_vld_q    <= 1'b0;
            tl_last_q   <= 1'b0;
            tl_err_q    <= 1'b0;
            tl_data_q   <= 8'h00;
            pkt_cnt_q   <= 8'h00;
            err_cnt_q   <= 8'h00;
        end else begin
            in_flight_q <= rd_en;
            pkt_cnt_q   <= pkt_sum[8] ? 8'hFF : pkt_sum[7:0];
            err_cnt_q   <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if (port_if.soft_reset) begin
                state_q  <= ST_HDR;
                hd_vld_q <= 1'b0;
                tl_vld_q <= 1'b0;
            end else begin
                // Head is the visible beat; the tail only fills while the head is occupied.
                if (pop && tl_vld_q) begin
                    hd_data_q <= tl_data_q;
                    hd_last_q <= tl_last_q;
                    hd_err_q  <= tl_err_q;
                    if (push) begin
                        tl_data_q <= port_if.data_in;
                        tl_last_q <= in_last;
                        tl_err_q  <= in_err;
                    end else begin
                        tl_vld_q <= 1'b0;
                    end
                end else if (pop) begin
                    if (push) begin
                        hd_data_q <= port_if.data_in;
                        hd_last_q <= in_last;
                        hd_err_q  <= in_err;
                    end else begin
                        hd_vld_q <= 1'b0;
                    end
                end else if (push) begin
                    if (hd_vld_q) begin
                        tl_data_q <= port_if.data_in;
                        tl_last_q <= in_last;
                        tl_err_q  <= in_err;
                        tl_vld_q  <= 1'b1;
                    end else begin
                        hd_data_q <= port_if.data_in;
                        hd_last_q <= in_last;
                        hd_err_q  <= in_err;
                        hd_vld_q  <= 1'b1;
                    end
                end

                if (push) begin
                    case (state_q)
                        ST_HDR: begin
                            cnt_q      <= port_if.data_in[7:2];
                            par_q      <= port_if.data_in;
                            addr_err_q <= (port_if.data_in[1:0] != PORT_ADDR[1:0]);
                            state_q    <= (port_if.data_in[7:2] != 6'd0) ? ST_PAYLOAD : ST_PARITY;
                        end
                        ST_PAYLOAD: begin
                            par_q <= par_q ^ port_if.data_in;
                            cnt_q <= cnt_q - 6'd1;
                            if (cnt_q == 6'd1) state_q <= ST_PARITY;
                        end
                        ST_PARITY: state_q <= ST_HDR;
                        default:   state_q <= ST_HDR;
                    endcase
                end
            end
        end
    end

    assign port_if.read_enb  = rd_en;
    assign port_if.m_data    = hd_data_q;
    assign port_if.m_valid   = hd_vld_q;
    assign port_if.m_last    = hd_last_q;
    assign port_if.m_err     = hd_err_q;
    assign port_if.pkt_cnt   = pkt_cnt_q;
    assign port_if.err_cnt   = err_cnt_q;
    assign port_if.dbg_state = state_q;
endmodule

// File: doc/router_out_port.md
ROUTER_OUT_PORT -- requirements
Module: router_out_port

Interface
REQ-001 Parameter PORT_ADDR, default 0, destination address (0..2) this output port serves.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 vld_in  input  1  output-FIFO not-empty (vld_out_x of the router).
REQ-005 data_in  input  8  output-FIFO read data (data_out_x), valid the cycle after read_enb.
REQ-006 soft_reset  input  1  FIFO soft-reset (timeout) indication from the synchronizer.
REQ-007 read_enb  output  1  FIFO read request.
REQ-008 m_data  output  8  delivered byte.
REQ-009 m_valid  output  1  m_data valid.
REQ-010 m_ready  input  1  sink accepts beat when m_valid & m_ready.
REQ-011 m_last  output  1  beat is parity byte (end of packet).
REQ-012 m_err  output  1  packet error, valid only on the m_last beat.
REQ-013 pkt_cnt  output  8  saturating count of completed packets.
REQ-014 err_cnt  output  8  saturating count of errored or aborted packets.

Function
REQ-015 Packet format SHALL be: header (length L = bits 7:2, address = bits 1:0), L payload bytes (L = 0 legal), parity byte = XOR of header and all payload bytes.
REQ-016 Block SHALL contain a 2-entry output buffer; m_data/m_valid/m_last/m_err SHALL come from the buffer head, registered.
REQ-017 read_enb SHALL be combinational: vld_in & ~soft_reset & (occupancy + in_flight - pop < 2), pop = m_valid & m_ready, in_flight = read_enb of previous cycle.
REQ-018 Byte read in cycle t SHALL be captured at end of cycle t+1; m_valid for it SHALL rise in cycle t+2 (buffer empty case).
REQ-019 Sustained throughput SHALL be one byte per cycle while vld_in and m_ready stay high.
REQ-020 Reads SHALL ignore packet boundaries; framing SHALL be derived solely from the captured byte stream.
REQ-021 Parser FSM states: HDR, PAYLOAD, PARITY; transitions on each captured byte.
REQ-022 HDR: load remaining count = L, load running parity = header, latch addr_err = (addr != PORT_ADDR); go PAYLOAD if L > 0 else PARITY.
REQ-023 PAYLOAD: XOR byte into parity, decrement count; go PARITY when count reaches 1 on capture.
REQ-024 PARITY: tag byte m_last = 1, m_err = (byte != running parity) | addr_err; go HDR.
REQ-025 pkt_cnt SHALL increment when the m_last beat is accepted; err_cnt SHALL increment when an m_last beat with m_err = 1 is accepted; both saturate at 255.
REQ-026 While m_valid & ~m_ready, m_data/m_last/m_err SHALL remain stable; no byte lost or duplicated.
REQ-027 vld_in dropping mid-packet SHALL only pause reads; FSM state and count SHALL be held.
REQ-028 soft_reset = 1 SHALL (next edge) flush buffer and in-flight byte, clear m_valid, return FSM to HDR; if FSM was not in HDR or buffer was non-empty, err_cnt SHALL increment by 1.
REQ-029 Simultaneous push and pop on a full buffer SHALL be accepted in the same cycle.

Reset
REQ-030 reset = 1 SHALL asynchronously force: FSM HDR, buffer empty, in_flight 0, read_enb 0, m_valid 0, m_data 0x00, m_last 0, m_err 0, pkt_cnt 0, err_cnt 0.
REQ-031 reset asserted mid-packet SHALL discard all partial packet state; first byte captured after release is treated as a header.

Verification
REQ-032 Reset mid-stream -> all outputs 0 within same cycle; post-release packet delivered correctly.
REQ-033 PORT_ADDR=0, FIFO holds 0x0C,0x11,0x22,0x33,0x0C, m_ready=1 -> read_enb first cycle vld_in high, m_valid 2 cycles later, 5 consecutive beats, m_last and m_err=0 on beat 5, pkt_cnt=1.
REQ-034 Same packet, parity byte 0xFF -> m_err=1 on last beat, pkt_cnt=1, err_cnt=1.
REQ-035 m_ready low 5 cycles mid-payload -> read_enb low after buffer fills, m_data stable, full 5-beat sequence delivered in order.
REQ-036 PORT_ADDR=1, packet 0x02,0x02 (L=0, addr 2) -> 2 beats, m_err=1 on beat 2; PORT_ADDR=2 same packet -> m_err=0.
REQ-037 soft_reset pulse after 2nd payload byte -> m_valid=0 next cycle, err_cnt+1, next header parsed correctly.
